cfg_reg_arbiter: RTL and testbench



---
 rtl/cfg_reg_arbiter_pkg.sv | 26 ++
 rtl/cfg_reg_arbiter_if.sv | 27 ++
 rtl/cfg_reg_arbiter_rr_arb2.sv | 41 ++++
 rtl/cfg_reg_arbiter.sv | 146 ++++++++++++++
 tb/tb_cfg_reg_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_reg_arbiter_pkg.sv
// Shared definitions for the PWM/output configuration bank:
// register addresses, bank size and FSM encoding.
package cfg_pkg;

    localparam int NUM_CFG_REGS = 5;

    localparam logic [2:0] ADDR_EN_OUT_LO = 3'd0;
    localparam logic [2:0] ADDR_EN_OUT_HI = 3'd1;
    localparam logic [2:0] ADDR_EN_PWM_LO = 3'd2;
    localparam logic [2:0] ADDR_EN_PWM_HI = 3'd3;
    localparam logic [2:0] ADDR_DUTY      = 3'd4;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef struct packed {
        logic       en;
        logic [2:0] addr;
        logic [7:0] data;
    } cfg_wr_t;

    function automatic logic addr_in_bank(input logic [2:0] addr);
        return addr < 3'(NUM_CFG_REGS);
    endfunction

endpackage

// File: rtl/cfg_reg_arbiter_if.sv
// Write-request bus shared by the SPI frame decoder (A) and the
// auxiliary ramp/test controller (B).
interface cfg_reg_arbiter_if;

    logic       a_valid;
    logic [2:0] a_addr;
    logic [7:0] a_data;
    logic       a_ready;

    logic       b_valid;
    logic [2:0] b_addr;
    logic [7:0] b_data;
    logic       b_ready;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );

endinterface

// File: rtl/cfg_reg_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/grant[0] is requester A.
// ptr = 0 favours A under contention, 1 favours B.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       ptr
);

    logic       r_ptr;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    // After a grant, priority passes to the requester that just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_grant[0]) begin
            r_ptr <= 1'b1;
        end else if (w_grant[1]) begin
            r_ptr <= 1'b0;
        end
    end

    assign grant = w_grant;
    assign ptr   = r_ptr;

endmodule

// File: rtl/cfg_reg_arbiter.sv
// PWM/output configuration bank: boot-loads defaults, then arbitrates
// single-register writes from two requesters.
//
//   state | meaning
//   BOOT  | one default written per cycle (idx 0..4), all requests stalled
//   RUN   | round-robin write arbitration, boot_done high
module cfg_reg_arbiter
    import cfg_pkg::*;
#(
    parameter logic [7:0] DEF_OUT_LO = 8'h00,
    parameter logic [7:0] DEF_OUT_HI = 8'h00,
    parameter logic [7:0] DEF_PWM_LO = 8'h00,
    parameter logic [7:0] DEF_PWM_HI = 8'h00,
    parameter logic [7:0] DEF_DUTY   = 8'h80
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cfg_reg_arbiter_if.slave        bus,
    input  logic                    reload_defaults,
    input  logic                    addr_err_clr,
    output logic [7:0]              en_reg_out_7_0,
    output logic [7:0]              en_reg_out_15_8,
    output logic [7:0]              en_reg_pwm_7_0,
    output logic [7:0]              en_reg_pwm_15_8,
    output logic [7:0]              pwm_duty_cycle,
    output logic                    boot_done,
    output logic                    addr_err
);

    logic [0:0] r_state;
    logic [2:0] r_boot_idx;
    logic [7:0] r_regs [NUM_CFG_REGS];
    logic       r_addr_err;

    logic       w_run;
    logic       w_arb_en;
    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_unused_ptr;
    cfg_wr_t    w_wr;
    logic       w_err_set;
    logic [7:0] w_boot_val;

    assign w_run = (r_state == ST_RUN);

    // A reload pulse suppresses grants in the cycle it is seen.
    assign w_arb_en = w_run & ~reload_defaults;
    assign w_req    = {bus.b_valid, bus.a_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_arb_en),
        .req   (w_req),
        .grant (w_grant),
        .ptr   (w_unused_ptr)
    );

    assign bus.a_ready = w_grant[0];
    assign bus.b_ready = w_grant[1];

    always_comb begin
        w_wr = '0;
        if (w_grant[1]) begin
            w_wr.en   = 1'b1;
            w_wr.addr = bus.b_addr;
            w_wr.data = bus.b_data;
        end else if (w_grant[0]) begin
            w_wr.en   = 1'b1;
            w_wr.addr = bus.a_addr;
            w_wr.data = bus.a_data;
        end
    end

    assign w_err_set = w_wr.en & ~addr_in_bank(w_wr.addr);

    always_comb begin
        w_boot_val = 8'h00;
        unique case (r_boot_idx)
            ADDR_EN_OUT_LO: w_boot_val = DEF_OUT_LO;
            ADDR_EN_OUT_HI: w_boot_val = DEF_OUT_HI;
            ADDR_EN_PWM_LO: w_boot_val = DEF_PWM_LO;
            ADDR_EN_PWM_HI: w_boot_val = DEF_PWM_HI;
            ADDR_DUTY:      w_boot_val = DEF_DUTY;
            default:        w_boot_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_boot_idx <= 3'd0;
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    if (r_boot_idx == ADDR_DUTY) begin
                        r_state    <= ST_RUN;
                        r_boot_idx <= 3'd0;
                    end else begin
                        r_boot_idx <= r_boot_idx + 3'd1;
                    end
                end
                ST_RUN: begin
                    if (reload_defaults) begin
                        r_state    <= ST_BOOT;
                        r_boot_idx <= 3'd0;
                    end
                end
                default: begin
                    r_state    <= ST_BOOT;
                    r_boot_idx <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CFG_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (!w_run) begin
            r_regs[r_boot_idx] <= w_boot_val;
        end else if (w_wr.en && addr_in_bank(w_wr.addr)) begin
            r_regs[w_wr.addr] <= w_wr.data;
        end
    end

    // Set beats clear so an error landing with a clear pulse is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err_set | (r_addr_err & ~addr_err_clr);
        end
    end

    assign en_reg_out_7_0  = r_regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = r_regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = r_regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = r_regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = r_regs[ADDR_DUTY];
    assign boot_done       = w_run;
    assign addr_err        = r_addr_err;

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed plus randomized bench for cfg_reg_arbiter against a
// cycle-level behavioural model of the bank.
module tb_cfg_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reload_defaults = 1'b0;
    logic       addr_err_clr = 1'b0;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       boot_done;
    logic       addr_err;

    cfg_reg_arbiter_if bus();

    cfg_reg_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .reload_defaults (reload_defaults),
        .addr_err_clr    (addr_err_clr),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .boot_done       (boot_done),
        .addr_err        (addr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: bank contents, boot progress, whose turn it is under contention.
    logic [7:0] defs   [5];
    logic [7:0] m_regs [5];
    bit         m_run;
    int         m_boot_cnt;
    bit         m_pref_b;
    bit         m_err;
    bit         g_a, g_b;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk8({pfx, "_out_lo"}, en_reg_out_7_0,  m_regs[0]);
        chk8({pfx, "_out_hi"}, en_reg_out_15_8, m_regs[1]);
        chk8({pfx, "_pwm_lo"}, en_reg_pwm_7_0,  m_regs[2]);
        chk8({pfx, "_pwm_hi"}, en_reg_pwm_15_8, m_regs[3]);
        chk8({pfx, "_duty"},   pwm_duty_cycle,  m_regs[4]);
        chk1({pfx, "_boot_done"}, boot_done, m_run);
        chk1({pfx, "_addr_err"},  addr_err,  m_err);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        m_run      = 1'b0;
        m_boot_cnt = 0;
        m_pref_b   = 1'b0;
        m_err      = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc();
        bit         ea, eb, set;
        logic [2:0] addr;
        logic [7:0] data;
        ea = 1'b0; eb = 1'b0; set = 1'b0;
        #1;
        if (m_run && !reload_defaults) begin
            if (bus.a_valid && bus.b_valid) begin
                if (m_pref_b) eb = 1'b1; else ea = 1'b1;
            end else if (bus.a_valid) begin
                ea = 1'b1;
            end else if (bus.b_valid) begin
                eb = 1'b1;
            end
        end
        chk1("a_ready", bus.a_ready, ea);
        chk1("b_ready", bus.b_ready, eb);
        chk1("boot_done_pre", boot_done, m_run);
        @(posedge clk);
        if (!m_run) begin
            m_regs[m_boot_cnt] = defs[m_boot_cnt];
            m_boot_cnt++;
            if (m_boot_cnt == 5) begin
                m_run      = 1'b1;
                m_boot_cnt = 0;
            end
        end else if (reload_defaults) begin
            m_run      = 1'b0;
            m_boot_cnt = 0;
        end else if (ea || eb) begin
            addr = ea ? bus.a_addr : bus.b_addr;
            data = ea ? bus.a_data : bus.b_data;
            if (addr < 3'd5) m_regs[int'(addr)] = data;
            else set = 1'b1;
            m_pref_b = ea;
        end
        if (set) m_err = 1'b1;
        else if (addr_err_clr) m_err = 1'b0;
        #1;
        check_outputs("post");
        g_a = ea;
        g_b = eb;
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases at the next negedge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk1("rst_a_ready", bus.a_ready, 1'b0);
        chk1("rst_b_ready", bus.b_ready, 1'b0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] a, input logic [7:0] d);
        bus.a_valid = v; bus.a_addr = a; bus.a_data = d;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] a, input logic [7:0] d);
        bus.b_valid = v; bus.b_addr = a; bus.b_data = d;
    endtask

    initial begin
        bit         pa, pb;
        logic [2:0] pa_addr, pb_addr;
        logic [7:0] pa_data, pb_data;

        defs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        model_reset();
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);

        // 1: boot from reset with no requests
        #2;
        check_outputs("init");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        chk8("t1_duty", pwm_duty_cycle, 8'h80);
        chk8("t1_out_lo", en_reg_out_7_0, 8'h00);
        chk1("t1_boot_done", boot_done, 1'b1);

        // 2: lone A write to duty
        drive_a(1'b1, 3'd4, 8'h3C);
        cyc();
        drive_a(1'b0, 3'd0, 8'h00);
        chk8("t2_duty", pwm_duty_cycle, 8'h3C);
        cyc();

        // 3: contention on the same address
        drive_a(1'b1, 3'd2, 8'hAA);
        drive_b(1'b1, 3'd2, 8'h55);
        cyc();
        drive_a(1'b0, 3'd0, 8'h00);
        cyc();
        drive_b(1'b0, 3'd0, 8'h00);
        chk8("t3_pwm_lo", en_reg_pwm_7_0, 8'h55);
        drive_a(1'b1, 3'd1, 8'h12);
        drive_b(1'b1, 3'd3, 8'h34);
        cyc();
        chk1("t3_ptr_back_to_a", g_a, 1'b1);
        drive_a(1'b0, 3'd0, 8'h00);
        cyc();
        drive_b(1'b0, 3'd0, 8'h00);

        // 4: bad address error, set-beats-clear, lone clear
        drive_b(1'b1, 3'd6, 8'hFF);
        cyc();
        drive_b(1'b0, 3'd0, 8'h00);
        chk1("t4_err_set", addr_err, 1'b1);
        drive_b(1'b1, 3'd7, 8'h01);
        addr_err_clr = 1'b1;
        cyc();
        drive_b(1'b0, 3'd0, 8'h00);
        addr_err_clr = 1'b0;
        chk1("t4_err_held", addr_err, 1'b1);
        addr_err_clr = 1'b1;
        cyc();
        addr_err_clr = 1'b0;
        chk1("t4_err_cleared", addr_err, 1'b0);

        // 5: A valid across BOOT is stalled, then accepted on the first RUN cycle
        drive_a(1'b1, 3'd1, 8'h5A);
        do_reset();
        repeat (5) cyc();
        cyc();
        chk1("t5_granted", g_a, 1'b1);
        drive_a(1'b0, 3'd0, 8'h00);
        chk8("t5_out_hi", en_reg_out_15_8, 8'h5A);

        // 6: reload with B pending, then reset in the third BOOT cycle
        drive_a(1'b1, 3'd0, 8'h11);
        cyc();
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b1, 3'd3, 8'h77);
        reload_defaults = 1'b1;
        cyc();
        reload_defaults = 1'b0;
        repeat (5) cyc();
        chk8("t6_restored_out_lo", en_reg_out_7_0, 8'h00);
        chk8("t6_restored_duty", pwm_duty_cycle, 8'h80);
        cyc();
        chk1("t6_b_first_run", g_b, 1'b1);
        drive_b(1'b0, 3'd0, 8'h00);
        chk8("t6_pwm_hi", en_reg_pwm_15_8, 8'h77);
        reload_defaults = 1'b1;
        cyc();
        reload_defaults = 1'b0;
        cyc();
        cyc();
        do_reset();
        repeat (5) cyc();
        chk8("t6_reboot_duty", pwm_duty_cycle, 8'h80);
        chk1("t6_reboot_done", boot_done, 1'b1);

        // randomized traffic with held requests
        pa = 1'b0; pb = 1'b0;
        pa_addr = 3'd0; pb_addr = 3'd0; pa_data = 8'h00; pb_data = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if (!pa && ($urandom_range(0, 2) == 0)) begin
                pa = 1'b1;
                pa_addr = 3'($urandom_range(0, 7));
                pa_data = 8'($urandom);
            end
            if (!pb && ($urandom_range(0, 2) == 0)) begin
                pb = 1'b1;
                pb_addr = 3'($urandom_range(0, 7));
                pb_data = 8'($urandom);
            end
            drive_a(pa, pa_addr, pa_data);
            drive_b(pb, pb_addr, pb_data);
            reload_defaults = ($urandom_range(0, 49) == 0);
            addr_err_clr    = ($urandom_range(0, 9) == 0);
            cyc();
            if (g_a) pa = 1'b0;
            if (g_b) pb = 1'b0;
        end
        reload_defaults = 1'b0;
        addr_err_clr    = 1'b0;
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
